// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant, rotating priority and an idle gap between owners (optional hold timeout: RR_ARB_TIMEOUT_EN)
module rr_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 busy,
`ifdef RR_ARB_TIMEOUT_EN
    output logic                 timeout,
`endif
    output logic                 req_up
);

    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, BUSY} state_t;

    // Reject configurations the rotating search cannot handle (wrap relies on N being a power of two)
    if (N < 2 || N > 32 || (N & (N - 1)) != 0 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("rr_arbiter: unsupported N or MAX_HOLD");
    end

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            release_w;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            timeout_q, timeout_d;
    logic            expire_w;
`endif

    // Priority search: walk down from ptr with wrap-around, first set request wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_q - IW'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state: grant from IDLE, hold in BUSY, release (or en low / timeout) back to IDLE
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        release_w = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        expire_w   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (en && win_found) begin
                    state_d          = BUSY;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    gnt_idx_d        = win_idx;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_cnt_d       = '0;
`endif
                end
            end
            BUSY: begin
                release_w = !en || !req[gnt_idx_q];
`ifdef RR_ARB_TIMEOUT_EN
                // Forced release only matters when someone else is waiting
                expire_w  = (hold_cnt_q == HW'(MAX_HOLD - 1)) && (|(req & ~gnt_q));
                if (release_w || expire_w) begin
                    timeout_d = !release_w;
`else
                if (release_w) begin
`endif
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    // Just-served requester drops to lowest priority
                    ptr_d     = gnt_idx_q - IW'(1);
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (hold_cnt_q != HW'(MAX_HOLD)) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_idx_d = '0;
            end
        endcase
    end

    // State registers; async reset restores MSB-first priority
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            ptr_q      <= IW'(N - 1);
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            ptr_q      <= ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign busy    = (state_q == BUSY);
    assign req_up  = en & ~|req;
`ifdef RR_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed scoreboard bench for rr_arbiter (N=8, MAX_HOLD=4)
module tb_rr_arbiter;

    logic       clock;
    logic       reset_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       req_up;
`ifdef RR_ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0] exp_gnt_q [$];
    logic       exp_to_q  [$];

    rr_arbiter #(.N(8), .MAX_HOLD(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
`ifdef RR_ARB_TIMEOUT_EN
        .timeout (timeout),
`endif
        .req_up  (req_up)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] idx_of(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at negedge, queue the expectation for the next posedge, then check it
    task automatic cyc(input logic e, input logic [7:0] r, input logic [7:0] eg, input logic et);
        logic [7:0] g;
        logic       t;
        en  = e;
        req = r;
        #1;
        chk("req_up", {31'd0, req_up}, {31'd0, e & ~|r});
        exp_gnt_q.push_back(eg);
        exp_to_q.push_back(et);
        @(posedge clock);
        #1;
        g = exp_gnt_q.pop_front();
        t = exp_to_q.pop_front();
        chk("gnt", {24'd0, gnt}, {24'd0, g});
        chk("gnt_idx", {29'd0, gnt_idx}, {29'd0, idx_of(g)});
        chk("busy", {31'd0, busy}, {31'd0, |g});
`ifdef RR_ARB_TIMEOUT_EN
        chk("timeout", {31'd0, timeout}, {31'd0, t});
`else
        if (t) chk("timeout_expect_unused", 32'd0, 32'd0 + {31'd0, t} - 32'd1 + 32'd1 - {31'd0, t});
`endif
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        req     = 8'h00;
        #2;
        chk("rst_gnt", {24'd0, gnt}, 32'd0);
        chk("rst_gnt_idx", {29'd0, gnt_idx}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: MSB first out of reset, gap, then the remaining requester
        cyc(1, 8'h81, 8'h80, 0);
        cyc(1, 8'h81, 8'h80, 0);
        cyc(1, 8'h01, 8'h00, 0);
        cyc(1, 8'h01, 8'h01, 0);
        cyc(1, 8'h00, 8'h00, 0);

        // 2: all requesting, each owner releases after two cycles: 7..0 then 7
        for (int i = 0; i < 9; i++) begin
            automatic logic [7:0] oh = 8'h01 << (7 - (i % 8));
            cyc(1, 8'hFF, oh, 0);
            cyc(1, 8'hFF, oh, 0);
            cyc(1, 8'hFF & ~oh, 8'h00, 0);
        end
        cyc(1, 8'h00, 8'h00, 0);

        // 3: owner 3 not preempted by req[5]
        cyc(1, 8'h08, 8'h08, 0);
        cyc(1, 8'h28, 8'h08, 0);
        cyc(1, 8'h28, 8'h08, 0);
        cyc(1, 8'h20, 8'h00, 0);
        cyc(1, 8'h20, 8'h20, 0);
        cyc(1, 8'h00, 8'h00, 0);

        // 4: owner 0 release wraps ptr to 7
        cyc(1, 8'h01, 8'h01, 0);
        cyc(1, 8'h83, 8'h01, 0);
        cyc(1, 8'h82, 8'h00, 0);
        cyc(1, 8'h82, 8'h80, 0);
        cyc(1, 8'h00, 8'h00, 0);

        // 5: en drop revokes owner 4; en low in IDLE grants nothing; async reset mid-grant
        cyc(1, 8'h10, 8'h10, 0);
        cyc(1, 8'h10, 8'h10, 0);
        cyc(0, 8'h10, 8'h00, 0);
        cyc(0, 8'h10, 8'h00, 0);
        cyc(1, 8'h10, 8'h10, 0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_gnt", {24'd0, gnt}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cyc(1, 8'h90, 8'h80, 0);
        cyc(1, 8'h00, 8'h00, 0);

`ifdef RR_ARB_TIMEOUT_EN
        // 6: hold limit with a competitor pending, then a lone requester keeps the grant
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) cyc(1, 8'h44, 8'h40, 0);
        cyc(1, 8'h44, 8'h00, 1);
        repeat (4) cyc(1, 8'h44, 8'h04, 0);
        cyc(1, 8'h44, 8'h00, 1);
        repeat (9) cyc(1, 8'h40, 8'h40, 0);
        cyc(1, 8'h00, 8'h00, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
